// File: rtl/execute_pkg.sv
// Shared constants for the execute stage: opcodes, functs, FSM states,
// op-class enum and a small opcode classifier.
package execute_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_R = 2'b00,
    CLS_J = 2'b01,
    CLS_I = 2'b10
  } op_cls_e;

  function automatic op_cls_e op_class(
    input logic [5:0] opc
  );
    op_cls_e c;
    if (opc == OP_RTYPE) begin
      c = CLS_R;
    end else if (opc == OP_J || opc == OP_JAL) begin
      c = CLS_J;
    end else begin
      c = CLS_I;
    end
    return c;
  endfunction

endpackage

// File: rtl/execute_mult_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: start/signed/a/b in; done (final cycle) and 64-bit product out.
module mult_iter #(
  parameter int MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [63:0] product_o
);

  localparam logic [5:0] LAST = 6'(MULT_CYCLES - 1);

  logic        busy_q;
  logic        neg_q;
  logic [5:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_d;

  always_comb begin
    a_neg = signed_i & a_i[31];
    b_neg = signed_i & b_i[31];
    a_mag = a_neg ? (32'd0 - a_i) : a_i;
    b_mag = b_neg ? (32'd0 - b_i) : b_i;
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    done_o = busy_q && (cnt_q == LAST);
    // Product includes the bit being added this cycle so the
    // caller can capture it on the same edge as done.
    product_o = neg_q ? (64'd0 - acc_d) : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      neg_q    <= a_neg ^ b_neg;
      cnt_q    <= '0;
      mcand_q  <= {32'd0, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 6'd1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute.sv
// MIPS execute stage: single-cycle ALU/branch ops, iterative mult.
// In: valid_in/insn/pc_in/rs_val/rt_val. Out: stall, wb_*, br_*, illegal.
module execute
  import execute_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] insn,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [31:0] sx;
  logic [31:0] zx;
  logic [31:0] br_off;
  op_cls_e     cls;

  logic        ex_wb;
  logic [4:0]  ex_dst;
  logic [31:0] ex_data;
  logic        ex_br;
  logic [31:0] ex_tgt;
  logic        ex_ill;
  logic        ex_mult;
  logic        ex_signed;

  logic        accept;
  logic        mult_done;
  logic [63:0] mult_prod;

  assign opc    = insn[31:26];
  assign fn     = insn[5:0];
  assign sh     = insn[10:6];
  assign imm    = insn[15:0];
  assign sx     = {{16{imm[15]}}, imm};
  assign zx     = {16'd0, imm};
  assign br_off = pc_in + 32'd4 + {sx[29:0], 2'b00};
  assign cls    = op_class(opc);
  assign accept = valid_in && (state_q == ST_IDLE);
  assign stall  = (state_q == ST_MULT);

  always_comb begin
    ex_wb     = 1'b0;
    ex_dst    = insn[15:11];
    ex_data   = '0;
    ex_br     = 1'b0;
    ex_tgt    = '0;
    ex_ill    = 1'b0;
    ex_mult   = 1'b0;
    ex_signed = 1'b0;
    unique case (1'b1)
      (cls == CLS_R): begin
        ex_wb = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: ex_data = rs_val + rt_val;
          FN_SUB, FN_SUBU: ex_data = rs_val - rt_val;
          FN_AND:  ex_data = rs_val & rt_val;
          FN_OR:   ex_data = rs_val | rt_val;
          FN_XOR:  ex_data = rs_val ^ rt_val;
          FN_NOR:  ex_data = ~(rs_val | rt_val);
          FN_SLT:
            ex_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: ex_data = {31'd0, rs_val < rt_val};
          FN_SLL:  ex_data = rt_val << sh;
          FN_SRL:  ex_data = rt_val >> sh;
          FN_SRA:  ex_data = 32'($signed(rt_val) >>> sh);
          FN_MFHI: ex_data = hi_q;
          FN_MFLO: ex_data = lo_q;
          FN_JR: begin
            ex_wb  = 1'b0;
            ex_br  = 1'b1;
            ex_tgt = rs_val;
          end
          FN_MULT, FN_MULTU: begin
            ex_wb     = 1'b0;
            ex_mult   = 1'b1;
            ex_signed = (fn == FN_MULT);
          end
          default: begin
            ex_wb  = 1'b0;
            ex_ill = 1'b1;
          end
        endcase
      end
      (cls == CLS_J): begin
        ex_br  = 1'b1;
        ex_tgt = {pc_in[31:28], insn[25:0], 2'b00};
        if (opc == OP_JAL) begin
          ex_wb   = 1'b1;
          ex_dst  = 5'd31;
          ex_data = pc_in + 32'd8;
        end
      end
      (cls == CLS_I): begin
        ex_dst = insn[20:16];
        ex_wb  = 1'b1;
        case (opc)
          OP_ADDI, OP_ADDIU: ex_data = rs_val + sx;
          OP_SLTI:
            ex_data = {31'd0, $signed(rs_val) < $signed(sx)};
          OP_SLTIU: ex_data = {31'd0, rs_val < sx};
          OP_ANDI:  ex_data = rs_val & zx;
          OP_ORI:   ex_data = rs_val | zx;
          OP_XORI:  ex_data = rs_val ^ zx;
          OP_LUI:   ex_data = {imm, 16'd0};
          OP_BEQ, OP_BNE: begin
            ex_wb  = 1'b0;
            ex_tgt = br_off;
            ex_br  = (rs_val == rt_val) ^ (opc == OP_BNE);
          end
          default: begin
            ex_wb  = 1'b0;
            ex_ill = 1'b1;
          end
        endcase
      end
      default: ex_ill = 1'b1;
    endcase
  end

  mult_iter #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && ex_mult),
    .signed_i (ex_signed),
    .a_i      (rs_val),
    .b_i      (rt_val),
    .done_o   (mult_done),
    .product_o(mult_prod)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    wb_valid_d  = 1'b0;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // r0 is never written, so its result is dropped.
          wb_valid_d = ex_wb && (ex_dst != 5'd0);
          if (wb_valid_d) begin
            wb_dst_d  = ex_dst;
            wb_data_d = ex_data;
          end
          br_taken_d = ex_br;
          if (ex_br) begin
            br_target_d = ex_tgt;
          end
          illegal_d = ex_ill;
          if (ex_mult) begin
            state_d = ST_MULT;
          end
        end
      end
      ST_MULT: begin
        if (mult_done) begin
          {hi_d, lo_d} = mult_prod;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      illegal_q   <= illegal_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_dst    = wb_dst_q;
  assign wb_data   = wb_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed vectors plus random
// instructions checked against a mnemonic-level reference model.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] insn;
  logic [31:0] pc_in;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  execute #(.MULT_CYCLES(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .insn     (insn),
    .pc_in    (pc_in),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall    (stall),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data),
    .br_taken (br_taken),
    .br_target(br_target),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {
    ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU,
    SLL, SRL, SRA, JR, MULT, MULTU, MFHI, MFLO,
    ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI,
    BEQ, BNE, J, JAL, ILLR, ILLI, NMN
  } mn_e;

  int total = 0;
  int bad   = 0;

  logic [4:0]  m_dst  = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_tgt  = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(
    input mn_e m, input logic [4:0] rsn, input logic [4:0] rtn,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [15:0] imm, input logic [25:0] tg);
    logic [5:0] f;
    logic [5:0] o;
    int k;
    f = 6'h00; o = 6'h00; k = 0;
    case (m)
      ADD: f = 6'h20;   ADDU: f = 6'h21;
      SUB: f = 6'h22;   SUBU: f = 6'h23;
      AND: f = 6'h24;   OR:   f = 6'h25;
      XOR: f = 6'h26;   NOR:  f = 6'h27;
      SLT: f = 6'h2a;   SLTU: f = 6'h2b;
      SLL: f = 6'h00;   SRL:  f = 6'h02;
      SRA: f = 6'h03;   JR:   f = 6'h08;
      MULT: f = 6'h18;  MULTU: f = 6'h19;
      MFHI: f = 6'h10;  MFLO: f = 6'h12;
      ILLR: f = 6'h01;
      ADDI:  begin o = 6'h08; k = 1; end
      ADDIU: begin o = 6'h09; k = 1; end
      SLTI:  begin o = 6'h0a; k = 1; end
      SLTIU: begin o = 6'h0b; k = 1; end
      ANDI:  begin o = 6'h0c; k = 1; end
      ORI:   begin o = 6'h0d; k = 1; end
      XORI:  begin o = 6'h0e; k = 1; end
      LUI:   begin o = 6'h0f; k = 1; end
      BEQ:   begin o = 6'h04; k = 1; end
      BNE:   begin o = 6'h05; k = 1; end
      ILLI:  begin o = 6'h3f; k = 1; end
      J:     begin o = 6'h02; k = 2; end
      JAL:   begin o = 6'h03; k = 2; end
      default: k = 0;
    endcase
    if (k == 1) return {o, rsn, rtn, imm};
    if (k == 2) return {o, tg};
    return {6'h00, rsn, rtn, rd, sh, f};
  endfunction

  task automatic run(input mn_e m, input logic [31:0] pc,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [4:0] rtn, input logic [4:0] rd,
                     input logic [4:0] sh, input logic [15:0] imm,
                     input logic [25:0] tg);
    logic        e_wb, e_br, e_ill, e_mul;
    logic [4:0]  e_dst;
    logic [31:0] e_data, e_tgt, sxi, zxi;
    logic [63:0] prod;
    string       nm;
    nm = m.name();
    sxi = {{16{imm[15]}}, imm};
    zxi = {16'd0, imm};
    e_wb = 1'b1; e_br = 1'b0; e_ill = 1'b0; e_mul = 1'b0;
    e_dst = rd; e_data = '0; e_tgt = '0; prod = '0;
    case (m)
      ADD, ADDU: e_data = rs + rt;
      SUB, SUBU: e_data = rs - rt;
      AND:  e_data = rs & rt;
      OR:   e_data = rs | rt;
      XOR:  e_data = rs ^ rt;
      NOR:  e_data = ~(rs | rt);
      SLT:  e_data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      SLTU: e_data = (rs < rt) ? 32'd1 : 32'd0;
      SLL:  e_data = rt << sh;
      SRL:  e_data = rt >> sh;
      SRA:  e_data = 32'($signed(rt) >>> sh);
      MFHI: e_data = m_hi;
      MFLO: e_data = m_lo;
      JR:   begin e_wb = 0; e_br = 1; e_tgt = rs; end
      MULT: begin
        e_wb = 0; e_mul = 1;
        prod = 64'(longint'($signed(rs)) * longint'($signed(rt)));
      end
      MULTU: begin
        e_wb = 0; e_mul = 1;
        prod = {32'd0, rs} * {32'd0, rt};
      end
      ADDI, ADDIU: begin e_dst = rtn; e_data = rs + sxi; end
      SLTI: begin
        e_dst = rtn;
        e_data = ($signed(rs) < $signed(sxi)) ? 32'd1 : 32'd0;
      end
      SLTIU: begin e_dst = rtn; e_data = (rs < sxi) ? 32'd1 : 32'd0; end
      ANDI: begin e_dst = rtn; e_data = rs & zxi; end
      ORI:  begin e_dst = rtn; e_data = rs | zxi; end
      XORI: begin e_dst = rtn; e_data = rs ^ zxi; end
      LUI:  begin e_dst = rtn; e_data = {imm, 16'd0}; end
      BEQ, BNE: begin
        e_wb = 0;
        e_br = (m == BEQ) ? (rs == rt) : (rs != rt);
        e_tgt = pc + 32'd4 + (sxi * 4);
      end
      J: begin e_wb = 0; e_br = 1; e_tgt = {pc[31:28], tg, 2'b00}; end
      JAL: begin
        e_br = 1; e_tgt = {pc[31:28], tg, 2'b00};
        e_dst = 5'd31; e_data = pc + 32'd8;
      end
      default: begin e_wb = 0; e_ill = 1; end
    endcase
    if (e_dst == 5'd0) e_wb = 1'b0;
    chk({nm, "_stall_pre"}, stall, 0);
    insn     = enc(m, 5'($urandom), rtn, rd, sh, imm, tg);
    pc_in    = pc;
    rs_val   = rs;
    rt_val   = rt;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    insn     = $urandom;
    if (e_wb) begin m_dst = e_dst; m_data = e_data; end
    if (e_br) m_tgt = e_tgt;
    chk({nm, "_wb_valid"}, wb_valid, e_wb);
    chk({nm, "_wb_dst"}, wb_dst, m_dst);
    chk({nm, "_wb_data"}, wb_data, m_data);
    chk({nm, "_br_taken"}, br_taken, e_br);
    chk({nm, "_br_target"}, br_target, m_tgt);
    chk({nm, "_illegal"}, illegal, e_ill);
    if (e_mul) begin
      for (int i = 0; i < 32; i++) begin
        chk({nm, "_stall_busy"}, stall, 1);
        @(posedge clk);
        #1;
      end
      chk({nm, "_stall_done"}, stall, 0);
      chk({nm, "_wb_quiet"}, wb_valid, 0);
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_br_taken", br_taken, 0);
    chk("idle_illegal", illegal, 0);
    chk("idle_wb_data", wb_data, m_data);
    chk("idle_br_target", br_target, m_tgt);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    insn     = '0;
    pc_in    = '0;
    rs_val   = '0;
    rt_val   = '0;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_br_target", br_target, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(ADDU, 32'h0, 32'hFFFF_FFFF, 32'h1, 5'd2, 5'd5, 5'd0, 16'h0, 26'h0);
    run(SLTI, 32'h0, 32'hFFFF_FFFE, 32'h0, 5'd8, 5'd0, 5'd0, 16'h1, 26'h0);
    run(SLTIU, 32'h0, 32'hFFFF_FFFE, 32'h0, 5'd9, 5'd0, 5'd0, 16'h1, 26'h0);
    run(BEQ, 32'h8002_0010, 32'h55, 32'h55, 5'd3, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    run(BNE, 32'h8002_0010, 32'h55, 32'h55, 5'd3, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    run(JAL, 32'h8002_0000, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
    run(ADDU, 32'h0, 32'h1234, 32'h1, 5'd2, 5'd0, 5'd0, 16'h0, 26'h0);
    run(SRA, 32'h0, 32'h0, 32'h8000_0000, 5'd2, 5'd4, 5'd31, 16'h0, 26'h0);
    run(ILLI, 32'h0, 32'h1, 32'h2, 5'd4, 5'd0, 5'd0, 16'h7, 26'h0);
    run(MULT, 32'h0, 32'hFFFF_FFFD, 32'h7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    run(MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0, 16'h0, 26'h0);
    run(MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd0, 16'h0, 26'h0);
    run(MULTU, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    run(MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd0, 16'h0, 26'h0);
    run(MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 5'd13, 5'd0, 16'h0, 26'h0);
    idle();

    for (int n = 0; n < 300; n++) begin
      mn_e         m;
      logic [31:0] rs, rt;
      m  = mn_e'($urandom_range(0, NMN - 1));
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      run(m, $urandom, rs, rt, 5'($urandom), 5'($urandom),
          5'($urandom), 16'($urandom), 26'($urandom));
      if ($urandom_range(0, 4) == 0) idle();
    end

    // Abort a multiply part-way through with reset.
    insn     = enc(MULT, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 26'h0);
    rs_val   = 32'h1234_5678;
    rt_val   = 32'h9ABC_DEF0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_dst = '0; m_data = '0; m_tgt = '0;
    chk("abort_stall", stall, 0);
    chk("abort_wb_data", wb_data, 0);
    chk("abort_wb_dst", wb_dst, 0);
    chk("abort_br_target", br_target, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 16'h0, 26'h0);
    run(MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, 16'h0, 26'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
